// File: rtl/sw_score_tracker_pkg.sv
// Shared definitions for the Smith-Waterman score tracker: default widths and FSM state encodings.
// SW_SCORE_WIDTH must match the WIDTH used by SmithWatermanPE.
package sw_score_tracker_pkg;

    localparam int SW_SCORE_WIDTH = 10;
    localparam int SW_COL_WIDTH   = 16;
    localparam int SW_THRESHOLD   = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sw_state_t;

endpackage

// File: rtl/sw_score_tracker.sv
// Follows the last SmithWatermanPE: tracks the best V score and its reference column per pass,
// then holds the result on a valid/ready interface until the host takes it.
module sw_score_tracker
    import sw_score_tracker_pkg::*;
#(
    parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
    parameter int COL_WIDTH   = SW_COL_WIDTH,
    parameter int THRESHOLD   = SW_THRESHOLD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COL_WIDTH-1:0]   ref_len,
    input  logic [SCORE_WIDTH-1:0] V_in,
    input  logic                   init_in,
    input  logic                   res_ready,
    output logic                   res_valid,
    output logic [SCORE_WIDTH-1:0] max_score,
    output logic [COL_WIDTH-1:0]   max_col,
    output logic                   hit,
    output logic                   busy
);

    localparam logic [SCORE_WIDTH-1:0] THRESH_V = SCORE_WIDTH'(THRESHOLD);

    sw_state_t              state;
    sw_state_t              next_state;
    logic [COL_WIDTH-1:0]   col;
    logic [COL_WIDTH-1:0]   ref_len_q;
    logic [COL_WIDTH-1:0]   last_col;
    logic [SCORE_WIDTH-1:0] best_score;
    logic [COL_WIDTH-1:0]   best_col;
    logic                   best_hit;
    logic                   start_pass;
    logic                   accept;

    assign last_col = ref_len_q - COL_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_pass = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_pass = 1'b1;
                    next_state = (ref_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (init_in) begin
                    accept = 1'b1;
                    if (col == last_col) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Strict greater-than keeps the earliest column on ties; hit moves with the score.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            ref_len_q  <= '0;
            best_score <= '0;
            best_col   <= '0;
            best_hit   <= 1'b0;
        end else if (start_pass) begin
            col        <= '0;
            ref_len_q  <= ref_len;
            best_score <= '0;
            best_col   <= '0;
            best_hit   <= 1'b0;
        end else if (accept) begin
            col <= col + COL_WIDTH'(1);
            if (V_in > best_score) begin
                best_score <= V_in;
                best_col   <= col;
                best_hit   <= (V_in >= THRESH_V);
            end
        end
    end

    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign max_score = best_score;
    assign max_col   = best_col;
    assign hit       = best_hit;

endmodule
